// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared widths, id constants and state encoding for the burst-read memory port
package mem_bus_pkg;
   localparam int MEM_AW = 30;
   localparam int MEM_DW = 32;
   localparam int MEM_IDW = 2;
   localparam logic [MEM_IDW-1:0] NO_ID = '0;
   typedef enum logic [1:0] {S_IDLE, S_RDREQ, S_COLLECT, S_WRREQ} state_t;
endpackage

// File: rtl/mem_line_filler.sv
// mem_line_filler: issues one burst line read or one masked word write on the shared memory port
module mem_line_filler
   import mem_bus_pkg::*;
#(
   parameter int BURST_BITS = 2,
   parameter logic [MEM_IDW-1:0] ID = 2'd1,
   parameter int TIMEOUT = 255
) (
   input  logic                              clock,
   input  logic                              rst_n,
   input  logic                              req_valid,
   output logic                              req_ready,
   input  logic                              req_write,
   input  logic [MEM_AW-1:0]                 req_addr,
   input  logic [MEM_DW-1:0]                 req_wdata,
   input  logic [3:0]                        req_wmask,
   output logic                              line_valid,
   output logic [(MEM_DW<<BURST_BITS)-1:0]   line_data,
   output logic                              busy,
   output logic                              error,
   input  logic                              mem_waitrequest,
   output logic [MEM_IDW-1:0]                mem_id,
   output logic [MEM_AW-1:0]                 mem_address,
   output logic                              mem_read,
   output logic                              mem_write,
   output logic [MEM_DW-1:0]                 mem_writedata,
   output logic [3:0]                        mem_writedatamask,
   input  logic [MEM_DW-1:0]                 mem_readdata,
   input  logic [MEM_IDW-1:0]                mem_readdataid
);
   localparam int N = 1 << BURST_BITS;
   state_t state;
   logic [MEM_DW-1:0] words [N];
   logic [BURST_BITS-1:0] cnt;
   logic [7:0] tmo;
   logic hit, last;
   assign req_ready = state == S_IDLE;
   assign busy = state != S_IDLE;
   assign mem_id = ID;
   // a tagged word may already arrive while the request is still being accepted
   assign hit = (mem_readdataid == ID) && (mem_readdataid != NO_ID) && (state == S_RDREQ || state == S_COLLECT);
   assign last = cnt == BURST_BITS'(N - 1);
   for (genvar g = 0; g < N; g++) begin : g_line
      assign line_data[MEM_DW*g +: MEM_DW] = words[g];
   end
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         mem_read <= 1'b0;
         mem_write <= 1'b0;
         line_valid <= 1'b0;
         error <= 1'b0;
         mem_address <= '0;
         mem_writedata <= '0;
         mem_writedatamask <= '0;
         cnt <= '0;
         tmo <= '0;
         for (int k = 0; k < N; k++) words[k] <= '0;
      end else begin
         line_valid <= 1'b0;
         if (hit) begin
            words[cnt] <= mem_readdata;
            cnt <= cnt + 1'b1;
            tmo <= '0;
         end
         case (state)
            S_IDLE: if (req_valid) begin
               error <= 1'b0;
               if (req_write) begin
                  mem_address <= req_addr;
                  mem_writedata <= req_wdata;
                  mem_writedatamask <= req_wmask;
                  mem_write <= 1'b1;
                  state <= S_WRREQ;
               end else begin
                  mem_address <= {req_addr[MEM_AW-1:BURST_BITS], BURST_BITS'(0)};
                  mem_read <= 1'b1;
                  cnt <= '0;
                  tmo <= '0;
                  state <= S_RDREQ;
               end
            end
            S_RDREQ: if (!mem_waitrequest) begin
               mem_read <= 1'b0;
               state <= S_COLLECT;
            end
            S_COLLECT: if (hit) begin
               if (last) begin
                  line_valid <= 1'b1;
                  state <= S_IDLE;
               end
            end else if (tmo == 8'(TIMEOUT - 1)) begin
               error <= 1'b1;
               state <= S_IDLE;
            end else begin
               tmo <= tmo + 8'd1;
            end
            S_WRREQ: if (!mem_waitrequest) begin
               mem_write <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: doc/mem_line_filler.md
Name: mem_line_filler

Overview:
Initiator for the id-tagged, burst-read memory port served by the SRAM controller. It accepts one client command at a time:
- a cache-line read, which issues one burst request and collects 2^BURST_BITS returned words into a line buffer, or
- a single masked word write.

It sits between a cache or refill client and the shared memory port, drives the port's request side and consumes its read-data side. This is the other end of the same protocol.

Parameters:
BURST_BITS, 2, log2 of words per burst/line; must match the responder's burst setting
ID, 2'd1, tag driven on mem_id and matched on mem_readdataid; must be nonzero (0 means "no data")
TIMEOUT, 255, max cycles waiting for the next read word before abort; 8-bit counter

Ports:
clock  in  1  sole clock, all state updates on rising edge
rst_n  in  1  asynchronous, active-low reset
req_valid  in  1  client command valid
req_ready  out  1  high only in S_IDLE; command taken when req_valid & req_ready
req_write  in  1  1 = single-word write, 0 = line read
req_addr  in  30  word address; low BURST_BITS forced to 0 for reads
req_wdata  in  32  write data
req_wmask  in  4  byte enables, 1 = write byte
line_valid  out  1  one-cycle pulse: line_data holds a completed line
line_data  out  32<<BURST_BITS  word k at bits [32k+31:32k], k = offset from base
busy  out  1  state != S_IDLE
error  out  1  sticky timeout flag, cleared on next accepted command
mem_waitrequest  in  1  responder stall
mem_id  out  2  constant ID
mem_address  out  30  registered request address
mem_read  out  1  read request
mem_write  out  1  write request
mem_writedata  out  32  write data
mem_writedatamask  out  4  byte enables
mem_readdata  in  32  returned word
mem_readdataid  in  2  tag of returned word; 0 = none

Behaviour:
- Reset values (async, rst_n low): state S_IDLE; mem_read, mem_write, line_valid, error = 0; mem_address, mem_writedata, line_data, word counter, timeout counter = 0; mem_writedatamask = 0; mem_id = ID always.
- All outputs are registered except req_ready and busy, which decode state.
- S_IDLE, command accepted:
  - Read: mem_address = {req_addr[29:BURST_BITS], 0}, mem_read = 1, word counter = 0, error = 0, go to S_RDREQ.
  - Write: load address, data and mask, mem_write = 1, error = 0, go to S_WRREQ.
  - mem_read/mem_write go high the cycle after acceptance.
- S_RDREQ: hold mem_read and mem_address stable while mem_waitrequest = 1.
  - On a cycle with mem_waitrequest = 0: the request is taken; clear mem_read next edge; go to S_COLLECT.
  - If a word tagged ID arrives in that same cycle, capture it (counter may advance from S_RDREQ).
- S_COLLECT: on each cycle with mem_readdataid == ID:
  - write mem_readdata into line_data slot [counter], counter +1, timeout counter cleared.
  - On the 2^BURST_BITS-th word: line_valid = 1 next cycle, go to S_IDLE; req_ready is high that same cycle.
- Words with any other tag are ignored in every state. This covers tags 0, foreign ids, and stale words after reset.
- Timeout: in S_COLLECT, the timeout counter increments on cycles without a matching word. On reaching TIMEOUT: error = 1, no line_valid, go to S_IDLE. line_data keeps its partial contents (not guaranteed meaningful).
- S_WRREQ: hold all write outputs while mem_waitrequest = 1. On acceptance, clear mem_write and return to S_IDLE. There is no write response.
- mem_read and mem_write are never high simultaneously.
- line_data is stable from the line_valid pulse until the first word of the next read.
- req_valid is ignored while busy; the client must hold it.
- Reset mid-burst returns to S_IDLE immediately. Later responder words are ignored because the state is idle.

Decomposition:
- Shared package mem_bus_pkg holds: state enum (S_IDLE, S_RDREQ, S_COLLECT, S_WRREQ), MEM_AW = 30, MEM_DW = 32, MEM_IDW = 2, and the constant NO_ID = 0.
- No sub-module is needed. The line buffer is a small register array inside the block.

Test Plan:
- Read at req_addr 0x0000_0105 against a responder returning 0xA0..0xA3 with id 1 and waitrequest 0 → mem_address = 0x104, mem_read high exactly one cycle, line_valid one pulse, line_data = {A3,A2,A1,A0}.
- Same read with mem_waitrequest held high 3 cycles → mem_read and mem_address stable for 4 cycles, single request taken, same line result.
- Interleave words tagged 2 and 0 between the id-1 words → foreign words ignored, line correct, completion delayed by the count of foreign cycles.
- Write of 0xDEADBEEF, mask 4'b0011 to 0x20 with waitrequest high 2 cycles → mem_write held 3 cycles, mask 0011, busy drops the cycle after acceptance, no line_valid.
- Responder drops after 2 words → error = 1 after 255 idle cycles, no line_valid, req_ready high; next command clears error.
- Assert rst_n low after the second word → all outputs at reset values immediately; residual id-1 words ignored; next read completes normally.
